// File: rtl/micro_op_serializer_pkg.sv
// Shared micro-op types for the serializer: op payload, counts, indices and pointer type.
// stamp_mop applies the per-slot bookkeeping fields when a micro op enters the buffer.
package micro_op_serializer_pkg;

  localparam int MOP_MAX          = 3;
  localparam int SERIALIZER_DEPTH = 16;
  localparam int MOP_IDX_W        = (MOP_MAX > 1) ? $clog2(MOP_MAX) : 1;
  localparam int MOP_CNT_W        = $clog2(MOP_MAX + 1);

  typedef logic [MOP_CNT_W-1:0] MicroOpCount;
  typedef logic [MOP_IDX_W-1:0] MicroOpIdx;

  // The extra top bit is the wrap flag that tells a full buffer from an empty one.
  typedef logic [$clog2(SERIALIZER_DEPTH):0] MicroOpSerializerPtr;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH
  } OpClass;

  typedef struct packed {
    logic      valid;
    logic      serialized;
    logic      split;
    logic      last;
    MicroOpIdx mid;
    OpClass    op_class;
    logic [7:0] opcode;
    logic [5:0] dest;
  } OpInfo;

  function automatic OpInfo stamp_mop(input OpInfo op, input MicroOpIdx idx,
                                      input MicroOpCount count);
    OpInfo stamped;
    stamped       = op;
    stamped.mid   = idx;
    stamped.last  = (int'(idx) + 1 == int'(count));
    stamped.split = (count > MicroOpCount'(1));
    stamped.valid = 1'b1;
    return stamped;
  endfunction

endpackage

// File: rtl/micro_op_serializer_if.sv
// Decode-side input group and issue-side output lanes of the micro-op serializer.
// The master modport is the surrounding pipeline; the slave modport is the serializer.
interface micro_op_serializer_if
  import micro_op_serializer_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int OUT_WIDTH    = 2
) ();

  logic [DECODE_WIDTH-1:0]                inValid;
  MicroOpCount [DECODE_WIDTH-1:0]         inMopCount;
  OpInfo [DECODE_WIDTH-1:0][MOP_MAX-1:0]  inMop;
  logic                                   inReady;
  logic [OUT_WIDTH-1:0]                   outValid;
  OpInfo [OUT_WIDTH-1:0]                  outMop;
  logic [$clog2(OUT_WIDTH+1)-1:0]         outAccept;

  modport master (
    output inValid,
    output inMopCount,
    output inMop,
    output outAccept,
    input  inReady,
    input  outValid,
    input  outMop
  );

  modport slave (
    input  inValid,
    input  inMopCount,
    input  inMop,
    input  outAccept,
    output inReady,
    output outValid,
    output outMop
  );

endinterface

// File: rtl/micro_op_serializer_prefix_sum.sv
// Exclusive prefix sum of micro-op counts over the valid decode lanes.
// offset[l] is where lane l's first micro op lands relative to the tail; total is the group size.
module micro_op_count_prefix_sum
  import micro_op_serializer_pkg::*;
#(
  parameter int DECODE_WIDTH = 2,
  parameter int TOT_W        = 3
) (
  input  logic [DECODE_WIDTH-1:0]             valid,
  input  MicroOpCount [DECODE_WIDTH-1:0]      counts,
  output logic [DECODE_WIDTH-1:0][TOT_W-1:0]  offset,
  output logic [TOT_W-1:0]                    total
);

  logic [TOT_W-1:0] running;

  always_comb begin
    running = '0;
    offset  = '0;
    for (int l = 0; l < DECODE_WIDTH; l++) begin
      offset[l] = running;
      if (valid[l]) begin
        running = running + TOT_W'(counts[l]);
      end
    end
    total = running;
  end

endmodule

// File: rtl/micro_op_serializer.sv
// Buffers whole decode groups of micro ops in a circular register array and
// re-emits them in program order, OUT_WIDTH per cycle, honouring serialized ops.
module micro_op_serializer #(
  parameter int DECODE_WIDTH = 2,
  parameter int MOP_MAX      = micro_op_serializer_pkg::MOP_MAX,
  parameter int OUT_WIDTH    = 2,
  parameter int DEPTH        = micro_op_serializer_pkg::SERIALIZER_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  micro_op_serializer_if.slave bus
);

  import micro_op_serializer_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TOT_W = $clog2(DECODE_WIDTH * MOP_MAX + 1);
  localparam int ACC_W = $clog2(OUT_WIDTH + 1);

  typedef logic [IDX_W:0]   ptr_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TOT_W-1:0] sum_t;
  typedef logic [ACC_W-1:0] acc_t;

  OpInfo entries [DEPTH];
  ptr_t  head_ptr;
  ptr_t  tail_ptr;
  ptr_t  occupancy;

  sum_t [DECODE_WIDTH-1:0] lane_offset;
  sum_t                    total;
  ptr_t                    free_slots;
  ptr_t                    accepted;
  logic                    in_ready;
  logic                    accept;

  logic  [DECODE_WIDTH-1:0][MOP_MAX-1:0] wr_en;
  idx_t  [DECODE_WIDTH-1:0][MOP_MAX-1:0] wr_idx;
  OpInfo [DECODE_WIDTH-1:0][MOP_MAX-1:0] wr_data;

  idx_t  [OUT_WIDTH-1:0] rd_idx;
  OpInfo [OUT_WIDTH-1:0] cand;
  logic  [OUT_WIDTH-1:0] out_valid;
  logic                  prefix_stop;
  acc_t                  n_valid;
  acc_t                  eff_accept;

  micro_op_count_prefix_sum #(
    .DECODE_WIDTH (DECODE_WIDTH),
    .TOT_W        (TOT_W)
  ) u_prefix_sum (
    .valid  (bus.inValid),
    .counts (bus.inMopCount),
    .offset (lane_offset),
    .total  (total)
  );

  // Admission looks only at registered occupancy, so the group is taken whole or not at all.
  always_comb begin
    free_slots = ptr_t'(DEPTH) - occupancy;
    in_ready   = rst_n && !flush && (free_slots >= ptr_t'(total));
    accept     = in_ready && (|bus.inValid);
    accepted   = accept ? ptr_t'(total) : '0;
  end

  always_comb begin
    wr_en   = '0;
    wr_idx  = '0;
    wr_data = '0;
    for (int l = 0; l < DECODE_WIDTH; l++) begin
      for (int m = 0; m < MOP_MAX; m++) begin
        wr_en[l][m]   = accept && bus.inValid[l] &&
                        (MicroOpCount'(m) < bus.inMopCount[l]);
        wr_idx[l][m]  = tail_ptr[IDX_W-1:0] + idx_t'(lane_offset[l]) + idx_t'(m);
        wr_data[l][m] = stamp_mop(bus.inMop[l][m], MicroOpIdx'(m), bus.inMopCount[l]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < DECODE_WIDTH; l++) begin
      for (int m = 0; m < MOP_MAX; m++) begin
        if (wr_en[l][m]) begin
          entries[wr_idx[l][m]] <= wr_data[l][m];
        end
      end
    end
  end

  always_comb begin
    rd_idx = '0;
    cand   = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      rd_idx[k] = head_ptr[IDX_W-1:0] + idx_t'(k);
      cand[k]   = entries[rd_idx[k]];
    end
  end

  // A serialized op must issue alone: it either owns lane 0 by itself or ends the prefix.
  always_comb begin
    out_valid   = '0;
    n_valid     = '0;
    prefix_stop = 1'b0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      if (ptr_t'(k) >= occupancy) begin
        prefix_stop = 1'b1;
      end
      if (k > 0 && (cand[k].serialized || cand[0].serialized)) begin
        prefix_stop = 1'b1;
      end
      if (!prefix_stop) begin
        out_valid[k] = 1'b1;
        n_valid      = n_valid + acc_t'(1);
      end
    end
    eff_accept = (bus.outAccept > n_valid) ? n_valid : bus.outAccept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head_ptr  <= '0;
      tail_ptr  <= '0;
      occupancy <= '0;
    end else begin
      head_ptr  <= head_ptr + ptr_t'(eff_accept);
      tail_ptr  <= tail_ptr + accepted;
      occupancy <= occupancy + accepted - ptr_t'(eff_accept);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (bus.outAccept <= n_valid)
        else $error("outAccept %0d exceeds %0d valid lanes", bus.outAccept, n_valid);
      assert (occupancy == ptr_t'(tail_ptr - head_ptr))
        else $error("occupancy %0d disagrees with pointers", occupancy);
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outValid = out_valid;
  assign bus.outMop   = cand;

endmodule

// File: tb/tb_micro_op_serializer.sv
// Directed bench for micro_op_serializer: reset, op stamping, serialization,
// backpressure at the buffer limit, wrap-around streaming, flush and mid-stream reset.
module tb_micro_op_serializer;
  import micro_op_serializer_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   assertCount = 0;
  int   failCount   = 0;
  int   expHead;
  int   nextOp;

  micro_op_serializer_if #(.DECODE_WIDTH(2), .OUT_WIDTH(2)) bus ();

  micro_op_serializer #(
    .DECODE_WIDTH (2),
    .MOP_MAX      (MOP_MAX),
    .OUT_WIDTH    (2),
    .DEPTH        (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bookkeeping fields start with wrong values so the stamping on write is visible.
  function automatic OpInfo makeOp(input int opcode, input logic ser);
    OpInfo op;
    op.valid      = 1'b0;
    op.serialized = ser;
    op.split      = 1'b1;
    op.last       = 1'b0;
    op.mid        = '1;
    op.op_class   = OP_LOAD;
    op.opcode     = 8'(opcode);
    op.dest       = 6'(opcode);
    return op;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkMop(input string tag, input int lane, input int opcode, input int mid,
                          input int last, input int split);
    checkOutput({tag, ".opcode"}, int'(bus.outMop[lane].opcode), opcode);
    checkOutput({tag, ".mid"},    int'(bus.outMop[lane].mid), mid);
    checkOutput({tag, ".last"},   int'(bus.outMop[lane].last), last);
    checkOutput({tag, ".split"},  int'(bus.outMop[lane].split), split);
    checkOutput({tag, ".valid"},  int'(bus.outMop[lane].valid), 1);
  endtask

  // Lane 1 opcodes continue right after lane 0's, matching program order.
  task automatic applyStimulus(input logic [1:0] valid, input int cnt0, input int cnt1,
                               input int firstOp, input logic [1:0] ser, input int accept);
    bus.inValid       = valid;
    bus.inMopCount[0] = MicroOpCount'(cnt0);
    bus.inMopCount[1] = MicroOpCount'(cnt1);
    for (int m = 0; m < MOP_MAX; m++) begin
      bus.inMop[0][m] = makeOp(firstOp + m, ser[0]);
      bus.inMop[1][m] = makeOp(firstOp + cnt0 + m, ser[1]);
    end
    bus.outAccept = 2'(accept);
    #1;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 0);
    repeat (2) waitCycle();
    checkOutput("resetInReady", int'(bus.inReady), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("postResetInReady", int'(bus.inReady), 1);
    checkOutput("postResetOutValid", int'(bus.outValid), 0);
    checkOutput("postResetOccupancy", int'(dut.occupancy), 0);

    // One instruction of three micro ops, visible only the cycle after it is written.
    applyStimulus(2'b01, 3, 0, 10, 2'b00, 0);
    checkOutput("mop3InReady", int'(bus.inReady), 1);
    checkOutput("mop3SameCycleOutValid", int'(bus.outValid), 0);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 2);
    checkOutput("mop3OutValid", int'(bus.outValid), 3);
    checkMop("mop3Lane0", 0, 10, 0, 0, 1);
    checkMop("mop3Lane1", 1, 11, 1, 0, 1);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 1);
    checkOutput("mop3TailOutValid", int'(bus.outValid), 1);
    checkMop("mop3Tail", 0, 12, 2, 1, 1);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 0);
    checkOutput("emptyOutValid", int'(bus.outValid), 0);

    // Serialized op at the head issues alone.
    applyStimulus(2'b11, 1, 2, 20, 2'b01, 0);
    checkOutput("serHeadInReady", int'(bus.inReady), 1);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 1);
    checkOutput("serHeadOutValid", int'(bus.outValid), 1);
    checkMop("serHead", 0, 20, 0, 1, 0);
    checkOutput("serHeadFlag", int'(bus.outMop[0].serialized), 1);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 2);
    checkOutput("serAfterOutValid", int'(bus.outValid), 3);
    checkMop("serAfterLane0", 0, 21, 0, 0, 1);
    checkMop("serAfterLane1", 1, 22, 1, 1, 1);
    waitCycle();

    // Serialized op in lane 1 cuts the prefix before it.
    applyStimulus(2'b11, 1, 1, 30, 2'b10, 0);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 1);
    checkOutput("serLane1OutValid", int'(bus.outValid), 1);
    checkOutput("serLane1Head", int'(bus.outMop[0].opcode), 30);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 1);
    checkOutput("serLane1NextOutValid", int'(bus.outValid), 1);
    checkOutput("serLane1Next", int'(bus.outMop[0].opcode), 31);
    waitCycle();
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 0);
    checkOutput("serDrainedOutValid", int'(bus.outValid), 0);

    // Fill to 14, then a group of 2+1 must wait until occupancy drops to 13.
    applyStimulus(2'b11, 3, 3, 40, 2'b00, 0);
    waitCycle();
    applyStimulus(2'b11, 3, 3, 46, 2'b00, 0);
    waitCycle();
    applyStimulus(2'b01, 2, 0, 52, 2'b00, 0);
    waitCycle();
    applyStimulus(2'b11, 2, 1, 54, 2'b00, 0);
    checkOutput("occ14InReady", int'(bus.inReady), 0);
    checkOutput("occ14Occupancy", int'(dut.occupancy), 14);
    waitCycle();
    checkOutput("occ14Held", int'(dut.occupancy), 14);
    applyStimulus(2'b11, 2, 1, 54, 2'b00, 1);
    checkOutput("occ14DrainInReady", int'(bus.inReady), 0);
    checkOutput("occ14HeadOp", int'(bus.outMop[0].opcode), 40);
    waitCycle();
    checkOutput("occ13Occupancy", int'(dut.occupancy), 13);
    applyStimulus(2'b11, 2, 1, 54, 2'b00, 0);
    checkOutput("occ13InReady", int'(bus.inReady), 1);
    waitCycle();
    checkOutput("fullOccupancy", int'(dut.occupancy), 16);

    // Full buffer refuses input but keeps draining.
    applyStimulus(2'b01, 1, 0, 57, 2'b00, 0);
    checkOutput("fullInReadyCnt1", int'(bus.inReady), 0);
    applyStimulus(2'b01, 2, 0, 57, 2'b00, 2);
    checkOutput("fullInReadyCnt2", int'(bus.inReady), 0);
    checkOutput("fullOutValid", int'(bus.outValid), 3);
    checkOutput("fullLane0", int'(bus.outMop[0].opcode), 41);
    checkOutput("fullLane1", int'(bus.outMop[1].opcode), 42);
    waitCycle();
    checkOutput("afterFullOccupancy", int'(dut.occupancy), 14);

    // Steady stream of 2 in / 2 out across the wrap point.
    expHead = 43;
    nextOp  = 57;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b01, 2, 0, nextOp, 2'b00, 2);
      checkOutput("streamInReady", int'(bus.inReady), 1);
      checkOutput("streamOutValid", int'(bus.outValid), 3);
      checkOutput("streamLane0", int'(bus.outMop[0].opcode), expHead);
      checkOutput("streamLane1", int'(bus.outMop[1].opcode), expHead + 1);
      waitCycle();
      expHead = expHead + 2;
      nextOp  = nextOp + 2;
    end
    checkOutput("streamOccupancy", int'(dut.occupancy), 14);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(2'b00, 0, 0, 0, 2'b00, 2);
      checkOutput("drainLane0", int'(bus.outMop[0].opcode), expHead);
      checkOutput("drainLane1", int'(bus.outMop[1].opcode), expHead + 1);
      waitCycle();
      expHead = expHead + 2;
    end
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 0);
    checkOutput("drainedOutValid", int'(bus.outValid), 0);
    checkOutput("drainedOccupancy", int'(dut.occupancy), 0);

    // Flush beats a same-cycle write and read.
    applyStimulus(2'b01, 3, 0, 100, 2'b00, 0);
    waitCycle();
    flush = 1'b1;
    applyStimulus(2'b11, 1, 1, 110, 2'b00, 2);
    checkOutput("flushInReady", int'(bus.inReady), 0);
    waitCycle();
    flush = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 0);
    checkOutput("flushOutValid", int'(bus.outValid), 0);
    checkOutput("flushOccupancy", int'(dut.occupancy), 0);
    checkOutput("flushHead", int'(dut.head_ptr), 0);
    checkOutput("flushTail", int'(dut.tail_ptr), 0);
    checkOutput("flushNextInReady", int'(bus.inReady), 1);

    // Reset in the middle of traffic at occupancy 9.
    applyStimulus(2'b11, 3, 3, 120, 2'b00, 0);
    waitCycle();
    applyStimulus(2'b01, 3, 0, 126, 2'b00, 0);
    waitCycle();
    checkOutput("midResetOccupancy", int'(dut.occupancy), 9);
    rst_n = 1'b0;
    applyStimulus(2'b11, 1, 1, 130, 2'b00, 1);
    checkOutput("midResetInReady", int'(bus.inReady), 0);
    waitCycle();
    rst_n = 1'b1;
    applyStimulus(2'b00, 0, 0, 0, 2'b00, 0);
    checkOutput("afterResetOccupancy", int'(dut.occupancy), 0);
    checkOutput("afterResetOutValid", int'(bus.outValid), 0);
    checkOutput("afterResetInReady", int'(bus.inReady), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
